// File: rtl/rst_seq_gen.sv
// Reset generator/sequencer: merges POR, SW, WDT and debounced button requests,
// enforces a minimum assertion width, then releases NUM_OUT reset domains in order.
// Optional macro RST_CAUSE_LOG_EN enables the reset-cause register on o_rst_cause.
module rst_seq_gen #(
  parameter int NUM_OUT    = 3,
  parameter int MIN_ASSERT = 16,
  parameter int STAGGER    = 4,
  parameter int DEBOUNCE   = 8
) (
  input  logic               i_sys_clk,
  input  logic               i_async_rst_n,
  input  logic               i_sw_rst_req,
  input  logic               i_wdt_timeout,
  input  logic               i_btn_rst_n,
  output logic [NUM_OUT-1:0] o_rst_n,
  output logic               o_busy,
  output logic [1:0]         o_rst_cause
);

  localparam int AW  = $clog2(MIN_ASSERT);
  localparam int SCW = $clog2(STAGGER + 1);
  localparam int IW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int DW  = $clog2(DEBOUNCE);

  localparam logic [AW-1:0]  A_LAST = AW'(MIN_ASSERT - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(STAGGER - 1);
  localparam logic [IW-1:0]  I_LAST = IW'(NUM_OUT - 1);
  localparam logic [DW-1:0]  D_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      acnt, acnt_nxt;
  logic [SCW-1:0]     scnt, scnt_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [NUM_OUT-1:0] rst_q, rst_nxt;
  logic               busy_q;

  logic               btn_s1, btn_s2;
  logic [DW-1:0]      deb_cnt;
  logic               btn_held;
  logic               btn_fire;
  logic               req;

  // Button path: 2-flop sync, low-run counter, one request per press.
  always_ff @(posedge i_sys_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      btn_s1   <= 1'b1;
      btn_s2   <= 1'b1;
      deb_cnt  <= '0;
      btn_held <= 1'b0;
    end else begin
      btn_s1 <= i_btn_rst_n;
      btn_s2 <= btn_s1;
      if (btn_s2)                deb_cnt <= '0;
      else if (deb_cnt != D_LAST) deb_cnt <= deb_cnt + 1'b1;
      if (btn_fire)    btn_held <= 1'b1;
      else if (btn_s2) btn_held <= 1'b0;
    end
  end

  assign btn_fire = !btn_s2 && (deb_cnt == D_LAST) && !btn_held;
  assign req      = btn_fire | i_wdt_timeout | i_sw_rst_req;

  always_ff @(posedge i_sys_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state  <= ST_ASSERT;
      acnt   <= '0;
      scnt   <= '0;
      idx    <= '0;
      rst_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      acnt   <= acnt_nxt;
      scnt   <= scnt_nxt;
      idx    <= idx_nxt;
      rst_q  <= rst_nxt;
      busy_q <= ~&rst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acnt_nxt  = acnt;
    scnt_nxt  = scnt;
    idx_nxt   = idx;
    rst_nxt   = rst_q;
    if (req) begin
      state_nxt = ST_ASSERT;
      acnt_nxt  = '0;
      scnt_nxt  = '0;
      idx_nxt   = '0;
      rst_nxt   = '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          // A held button keeps the width counter parked until it is let go.
          if (btn_held) begin
            acnt_nxt = '0;
          end else if (acnt == A_LAST) begin
            acnt_nxt   = '0;
            rst_nxt[0] = 1'b1;
            if (NUM_OUT == 1) begin
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_RELEASE;
              idx_nxt   = IW'(1);
              scnt_nxt  = '0;
            end
          end else begin
            acnt_nxt = acnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (scnt == S_LAST) begin
            scnt_nxt = '0;
            for (int k = 0; k < NUM_OUT; k++)
              if (idx == IW'(k)) rst_nxt[k] = 1'b1;
            if (idx == I_LAST) state_nxt = ST_RUN;
            else               idx_nxt   = idx + 1'b1;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
        ST_RUN:  ;
        default: state_nxt = ST_ASSERT;
      endcase
    end
  end

  assign o_rst_n = rst_q;
  assign o_busy  = busy_q;

`ifdef RST_CAUSE_LOG_EN
  logic [1:0] cause_q;

  always_ff @(posedge i_sys_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n)  cause_q <= 2'b00;
    else if (req)        cause_q <= btn_fire ? 2'b11 : (i_wdt_timeout ? 2'b10 : 2'b01);
  end

  assign o_rst_cause = cause_q;
`else
  assign o_rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed spot checks plus randomized requests compared
// every cycle against an anchor-based release model.
module tb_rst_seq_gen;
  localparam int NUM_OUT    = 3;
  localparam int MIN_ASSERT = 16;
  localparam int STAGGER    = 4;
  localparam int DEBOUNCE   = 8;

`ifdef RST_CAUSE_LOG_EN
  localparam logic [1:0] C_SW  = 2'b01;
  localparam logic [1:0] C_WDT = 2'b10;
  localparam logic [1:0] C_BTN = 2'b11;
`else
  localparam logic [1:0] C_SW  = 2'b00;
  localparam logic [1:0] C_WDT = 2'b00;
  localparam logic [1:0] C_BTN = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0, wdt = 1'b0, btn = 1'b1;
  logic [NUM_OUT-1:0] rst_o;
  logic busy;
  logic [1:0] cause;

  always #5 clk = ~clk;

  rst_seq_gen #(.NUM_OUT(NUM_OUT), .MIN_ASSERT(MIN_ASSERT), .STAGGER(STAGGER), .DEBOUNCE(DEBOUNCE)) dut (
    .i_sys_clk    (clk),
    .i_async_rst_n(rst_n),
    .i_sw_rst_req (sw),
    .i_wdt_timeout(wdt),
    .i_btn_rst_n  (btn),
    .o_rst_n      (rst_o),
    .o_busy       (busy),
    .o_rst_cause  (cause)
  );

  int cmps = 0;
  int errs = 0;

  // Model: bit k is high once (edge - anchor) >= MIN_ASSERT + k*STAGGER,
  // anchor being the last request edge or debounced button release edge.
  int n, anchor, low_run;
  bit held, d0, d1;
  bit model_en = 1'b0;
  logic [1:0] m_cause;
  logic [NUM_OUT-1:0] m_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    n = 0; anchor = 0; low_run = 0; held = 1'b0; d0 = 1'b1; d1 = 1'b1; m_cause = 2'b00;
  endfunction

  function automatic logic [NUM_OUT-1:0] exp_rst();
    logic [NUM_OUT-1:0] v;
    for (int k = 0; k < NUM_OUT; k++)
      v[k] = !held && ((n - anchor) >= MIN_ASSERT + k * STAGGER);
    return v;
  endfunction

  function automatic logic [1:0] exp_cause();
`ifdef RST_CAUSE_LOG_EN
    return m_cause;
`else
    return 2'b00;
`endif
  endfunction

  always @(posedge clk) begin
    if (model_en) begin
      bit bs, fire, req;
      n++;
      bs = d1; d1 = d0; d0 = btn;
      low_run = bs ? 0 : low_run + 1;
      if (held && bs) begin held = 1'b0; anchor = n; end
      fire = !held && !bs && (low_run >= DEBOUNCE);
      req  = sw | wdt | fire;
      if (req) begin
        anchor  = n;
        m_cause = fire ? 2'b11 : (wdt ? 2'b10 : 2'b01);
        if (fire) held = 1'b1;
      end
      #1;
      if (model_en) begin
        m_rst = exp_rst();
        chk("model_rst_n", rst_o, m_rst);
        chk("model_busy", busy, ~&m_rst);
        chk("model_cause", cause, exp_cause());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  // Expects the reference edge (request, release or POR deassert) to be current.
  task automatic rel_check(input string tag);
    ticks(MIN_ASSERT - 1);
    chk({tag, "_pre"}, rst_o, 3'b000);
    tick();
    chk({tag, "_b0"}, rst_o, 3'b001);
    ticks(STAGGER);
    chk({tag, "_b1"}, rst_o, 3'b011);
    chk({tag, "_busy_mid"}, busy, 1'b1);
    ticks(STAGGER);
    chk({tag, "_b2"}, rst_o, 3'b111);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic por_release();
    rst_n = 1'b1;
    model_reset();
    model_en = 1'b1;
  endtask

  initial begin
    int btn_left;
    model_reset();
    ticks(3);
    chk("por_rst_n", rst_o, 3'b000);
    chk("por_busy", busy, 1'b1);
    chk("por_cause", cause, 2'b00);

    por_release();
    rel_check("por");
    chk("por_cause_end", cause, 2'b00);
    ticks(5);

    sw = 1'b1; tick(); sw = 1'b0;
    chk("sw_assert", rst_o, 3'b000);
    chk("sw_busy", busy, 1'b1);
    rel_check("sw");
    chk("sw_cause", cause, C_SW);
    ticks(3);

    sw = 1'b1; wdt = 1'b1; tick(); sw = 1'b0; wdt = 1'b0;
    chk("wdt_assert", rst_o, 3'b000);
    rel_check("wdt");
    chk("wdt_cause", cause, C_WDT);

    btn = 1'b0; ticks(5); btn = 1'b1; ticks(20);
    chk("glitch_ignored", rst_o, 3'b111);
    chk("glitch_cause", cause, C_WDT);

    btn = 1'b0; ticks(40);
    chk("btn_held_low", rst_o, 3'b000);
    chk("btn_cause", cause, C_BTN);
    btn = 1'b1; ticks(2);
    chk("btn_sync_lag", rst_o, 3'b000);
    tick();
    rel_check("btn");

    sw = 1'b1; tick(); sw = 1'b0;
    ticks(MIN_ASSERT + STAGGER);
    chk("rel_mid", rst_o, 3'b011);
    sw = 1'b1; tick(); sw = 1'b0;
    chk("rel_restart", rst_o, 3'b000);
    rel_check("restart");

    sw = 1'b1; tick(); sw = 1'b0;
    ticks(MIN_ASSERT + 2);
    chk("pre_async", rst_o, 3'b001);
    rst_n = 1'b0; model_en = 1'b0; #1;
    chk("async_rst_n", rst_o, 3'b000);
    chk("async_busy", busy, 1'b1);
    chk("async_cause", cause, 2'b00);
    ticks(2);
    por_release();
    rel_check("por2");
    chk("por2_cause", cause, 2'b00);

    btn_left = 0;
    for (int i = 0; i < 4000; i++) begin
      sw  = ($urandom_range(0, 59) == 0);
      wdt = ($urandom_range(0, 59) == 0);
      if (btn_left == 0 && $urandom_range(0, 79) == 0) btn_left = $urandom_range(1, 30);
      btn = (btn_left == 0);
      if (btn_left > 0) btn_left--;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0; model_en = 1'b0; #1;
        chk("rand_async_rst_n", rst_o, 3'b000);
        ticks(2);
        por_release();
      end
      tick();
    end
    sw = 1'b0; wdt = 1'b0; btn = 1'b1;
    ticks(60);
    model_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
